// File: rtl/bus_pkg.sv
// Shared data-bus definitions for memory-mapped peripherals.
// Holds the bus mode and access-width encodings, plus the timer register offsets
// and CTRL bit positions so that other bus peripherals can reuse the same map.
package bus_pkg;

    // Bus mode (data_bus_mode); 2'b11 is reserved and decodes as idle
    localparam logic [1:0] BUS_MODE_IDLE  = 2'b00;
    localparam logic [1:0] BUS_MODE_READ  = 2'b01;
    localparam logic [1:0] BUS_MODE_WRITE = 2'b10;

    // Access width (data_bus_reqw)
    localparam logic [1:0] BUS_W_BYTE = 2'b00;
    localparam logic [1:0] BUS_W_HALF = 2'b01;
    localparam logic [1:0] BUS_W_WORD = 2'b10;

    // Timer word-slot offsets (addr[4:2])
    localparam logic [2:0] TMR_OFF_CTRL     = 3'd0;
    localparam logic [2:0] TMR_OFF_STATUS   = 3'd1;
    localparam logic [2:0] TMR_OFF_COUNT    = 3'd2;
    localparam logic [2:0] TMR_OFF_COMPARE  = 3'd3;
    localparam logic [2:0] TMR_OFF_PRESCALE = 3'd4;

    // CTRL bit indices
    localparam int unsigned TMR_CTRL_EN = 0;
    localparam int unsigned TMR_CTRL_IE = 1;
    localparam int unsigned TMR_CTRL_AR = 2;

    // Stalled-load response FSM
    typedef enum logic {
        StIdle,
        StPresent
    } rd_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Timer prescaler: divides clk by (prescale + 1) while enabled.
// Ports:
//   clk      - system clock
//   reset    - synchronous active-high reset
//   en       - count enable; low holds the internal counter at 0
//   prescale - terminal count; 0 gives a tick every cycle
//   tick     - high for one cycle each time the counter reaches prescale
module timer_prescaler (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] prescale,
    output logic        tick
);

    logic [15:0] pcnt_q, pcnt_d;

    always_comb begin
        // >= keeps the divider from running through a full 16-bit wrap if
        // software lowers prescale below the current count
        tick   = en && (pcnt_q >= prescale);
        pcnt_d = pcnt_q + 16'd1;
        if (!en || tick) begin
            pcnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped 32-bit compare timer on the core data bus.
// Word writes only; loads are answered in the cycle after a stall_lw cycle from a
// registered copy of the selected register. Compare match raises an active-low IRQ.
// Ports:
//   clk, reset     - system clock, synchronous active-high reset
//   stall_lw       - first cycle of a stalled load
//   data_bus_addr  - byte address
//   data_bus_mode  - idle / read / write
//   data_bus_reqw  - access width (writes must be word; ignored for reads)
//   data_bus_reqs  - sign-extend request, unused
//   data_bus_data  - write data in, read data out, high-Z when not answering
//   irq_n          - registered active-low interrupt request
module bus_timer
    import bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0001_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_lw,
    input  logic [31:0] data_bus_addr,
    input  logic [1:0]  data_bus_mode,
    input  logic [1:0]  data_bus_reqw,
    input  logic        data_bus_reqs,
    inout  wire  [31:0] data_bus_data,
    output logic        irq_n
);

    logic        sel, rd_sel, wr_en, tick, match, drive;
    logic [2:0]  off;
    logic [31:0] wdata, rd_mux;
    logic        unused_reqs;

    logic [2:0]  ctrl_q, ctrl_d;
    logic        pend_q, pend_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [15:0] prescale_q, prescale_d;
    logic        irq_n_q, irq_n_d;
    logic [31:0] rdata_q, rdata_d;
    rd_state_e   state_q, state_d;

    assign unused_reqs = data_bus_reqs;

    assign sel    = (data_bus_addr[31:5] == BASE_ADDR[31:5]) && (data_bus_addr[1:0] == 2'b00);
    assign off    = data_bus_addr[4:2];
    assign wr_en  = (data_bus_mode == BUS_MODE_WRITE) && sel && (data_bus_reqw == BUS_W_WORD);
    assign rd_sel = (data_bus_mode == BUS_MODE_READ) && sel;
    assign wdata  = data_bus_data;

    timer_prescaler u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .en       (ctrl_q[TMR_CTRL_EN]),
        .prescale (prescale_q),
        .tick     (tick)
    );

    // Match always uses the current COMPARE, so a same-cycle COMPARE write
    // only affects later ticks
    assign match = tick && (count_q == compare_q);

    always_comb begin
        ctrl_d     = ctrl_q;
        pend_d     = pend_q;
        count_d    = count_q;
        compare_d  = compare_q;
        prescale_d = prescale_q;

        if (tick) begin
            count_d = (match && ctrl_q[TMR_CTRL_AR]) ? 32'd0 : count_q + 32'd1;
        end

        // Register writes are applied after the tick so a COUNT write wins
        if (wr_en) begin
            case (off)
                TMR_OFF_CTRL:     ctrl_d     = wdata[2:0];
                TMR_OFF_STATUS:   if (wdata[0]) pend_d = 1'b0;
                TMR_OFF_COUNT:    count_d    = wdata;
                TMR_OFF_COMPARE:  compare_d  = wdata;
                TMR_OFF_PRESCALE: prescale_d = wdata[15:0];
                default:          ;
            endcase
        end

        // A new match beats a same-cycle W1C
        if (match) begin
            pend_d = 1'b1;
        end

        irq_n_d = ~(pend_q & ctrl_q[TMR_CTRL_IE]);
    end

    always_comb begin
        rd_mux = '0;
        case (off)
            TMR_OFF_CTRL:     rd_mux = {29'd0, ctrl_q};
            TMR_OFF_STATUS:   rd_mux = {31'd0, pend_q};
            TMR_OFF_COUNT:    rd_mux = count_q;
            TMR_OFF_COMPARE:  rd_mux = compare_q;
            TMR_OFF_PRESCALE: rd_mux = {16'd0, prescale_q};
            default:          rd_mux = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (rd_sel && stall_lw) begin
                    state_d = StPresent;
                    rdata_d = rd_mux;
                end
            end
            StPresent: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    assign drive         = (state_q == StPresent) && rd_sel;
    assign data_bus_data = drive ? rdata_q : {32{1'bz}};
    assign irq_n         = irq_n_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q     <= '0;
            pend_q     <= 1'b0;
            count_q    <= '0;
            compare_q  <= 32'hFFFF_FFFF;
            prescale_q <= '0;
            irq_n_q    <= 1'b1;
            rdata_q    <= '0;
            state_q    <= StIdle;
        end else begin
            ctrl_q     <= ctrl_d;
            pend_q     <= pend_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            prescale_q <= prescale_d;
            irq_n_q    <= irq_n_d;
            rdata_q    <= rdata_d;
            state_q    <= state_d;
        end
    end

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: a register readback table plus hand-written
// sequences for counting, auto-reload, IRQ timing, W1C races, reset and wrap.
// Expected read data is queued when a load is issued and popped when the DUT answers.
module tb_bus_timer;
    import bus_pkg::*;

    localparam logic [31:0] BASE = 32'h0001_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [31:0] addr;
    logic [1:0]  mode;
    logic [1:0]  reqw;
    logic        reqs;
    logic [31:0] tb_wdata;
    logic        tb_oe;
    logic        irq_n;
    wire  [31:0] data_bus_data;

    // Released bus reads as all ones
    pullup (data_bus_data);
    assign data_bus_data = tb_oe ? tb_wdata : {32{1'bz}};

    bus_timer #(
        .BASE_ADDR (BASE)
    ) dut (
        .clk           (clk),
        .reset         (rst),
        .stall_lw      (stall),
        .data_bus_addr (addr),
        .data_bus_mode (mode),
        .data_bus_reqw (reqw),
        .data_bus_reqs (reqs),
        .data_bus_data (data_bus_data),
        .irq_n         (irq_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        string       name;
        logic [7:0]  off;
        logic        do_wr;
        logic [1:0]  reqw;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input string n, input logic [7:0] o, input logic w, input logic [1:0] rw,
                       input logic [31:0] wd, input logic [31:0] e);
        vec_t v;
        v.name = n; v.off = o; v.do_wr = w; v.reqw = rw; v.wdata = wd; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_rel(input string name);
        chk({name, " released"}, data_bus_data, 32'hFFFF_FFFF);
    endtask

    task automatic pop_chk(input string name);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got %h expected <nothing queued>", name, data_bus_data);
        end else begin
            e = exp_q.pop_front();
            chk(name, data_bus_data, e);
        end
    endtask

    task automatic idle_in();
        mode  = BUS_MODE_IDLE;
        stall = 1'b0;
        tb_oe = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_in();
        step();
        rst = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
        mode = BUS_MODE_WRITE; addr = a; reqw = w; tb_wdata = d; tb_oe = 1'b1; stall = 1'b0;
        step();
        idle_in();
    endtask

    // Stall cycle, present cycle, then one more selected read cycle: 3 clocks
    task automatic rd(input logic [31:0] a, input logic [1:0] w, input logic [31:0] exp,
                      input string name);
        mode = BUS_MODE_READ; addr = a; reqw = w; stall = 1'b1; tb_oe = 1'b0;
        @(negedge clk);
        chk_rel({name, "/stall"});
        exp_q.push_back(exp);
        step();
        stall = 1'b0;
        @(negedge clk);
        pop_chk(name);
        step();
        @(negedge clk);
        chk_rel({name, "/after"});
        step();
        idle_in();
    endtask

    task automatic rd_unsel(input logic [31:0] a, input string name);
        mode = BUS_MODE_READ; addr = a; reqw = BUS_W_WORD; stall = 1'b1; tb_oe = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_rel(name);
            step();
            stall = 1'b0;
        end
        idle_in();
    endtask

    task automatic wait_cyc(input int t);
        int budget;
        budget = 1000;
        while (cyc < t && budget > 0) begin
            step();
            budget--;
        end
    endtask

    task automatic chk_irq(input string name, input logic e);
        @(negedge clk);
        chk(name, {31'd0, irq_n}, {31'd0, e});
        step();
    endtask

    int e;

    initial begin
        rst = 1'b1; stall = 1'b0; addr = '0; mode = BUS_MODE_IDLE; reqw = BUS_W_WORD;
        reqs = 1'b0; tb_wdata = '0; tb_oe = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        @(negedge clk);
        chk_rel("reset bus");
        chk("reset irq_n", {31'd0, irq_n}, 32'd1);
        step();

        // Register readback table (timer disabled throughout)
        add("rst ctrl",       8'h00, 1'b0, BUS_W_WORD, 32'h0,         32'h0);
        add("rst status",     8'h04, 1'b0, BUS_W_WORD, 32'h0,         32'h0);
        add("rst count",      8'h08, 1'b0, BUS_W_WORD, 32'h0,         32'h0);
        add("rst compare",    8'h0C, 1'b0, BUS_W_WORD, 32'h0,         32'hFFFF_FFFF);
        add("rst prescale",   8'h10, 1'b0, BUS_W_WORD, 32'h0,         32'h0);
        add("prescale wr",    8'h10, 1'b1, BUS_W_WORD, 32'hABCD_1234, 32'h0000_1234);
        add("compare wr",     8'h0C, 1'b1, BUS_W_WORD, 32'h5A5A_0001, 32'h5A5A_0001);
        add("count wr",       8'h08, 1'b1, BUS_W_WORD, 32'h00C0_FFEE, 32'h00C0_FFEE);
        add("count byte rd",  8'h08, 1'b0, BUS_W_BYTE, 32'h0,         32'h00C0_FFEE);
        add("ctrl byte wr",   8'h00, 1'b1, BUS_W_BYTE, 32'h0000_00FF, 32'h0);
        add("ctrl half wr",   8'h00, 1'b1, BUS_W_HALF, 32'h0000_00FF, 32'h0);
        add("status w1c idle",8'h04, 1'b1, BUS_W_WORD, 32'h1,         32'h0);
        add("unmapped 0x14",  8'h14, 1'b1, BUS_W_WORD, 32'h1234,      32'h0);
        add("unmapped 0x1c",  8'h1C, 1'b0, BUS_W_WORD, 32'h0,         32'h0);
        foreach (vecs[i]) begin
            if (vecs[i].do_wr) wr(BASE + {24'd0, vecs[i].off}, vecs[i].wdata, vecs[i].reqw);
            rd(BASE + {24'd0, vecs[i].off}, vecs[i].reqw, vecs[i].exp, vecs[i].name);
        end
        rd_unsel(BASE + 32'h20, "unsel +0x20");
        rd_unsel(BASE + 32'h09, "misaligned +0x09");

        // Free-running count, no reload: PEND on the 6th tick, IRQ one cycle later
        do_reset();
        wr(BASE + 32'h10, 32'd0, BUS_W_WORD);
        wr(BASE + 32'h0C, 32'd5, BUS_W_WORD);
        wr(BASE + 32'h08, 32'd0, BUS_W_WORD);
        wr(BASE + 32'h00, 32'h3, BUS_W_WORD);
        e = cyc;
        wait_cyc(e + 6);
        chk_irq("s1 irq at match edge", 1'b1);
        chk_irq("s1 irq after match", 1'b0);
        rd(BASE + 32'h08, BUS_W_WORD, 32'(cyc - e), "s1 count past compare a");
        rd(BASE + 32'h08, BUS_W_WORD, 32'(cyc - e), "s1 count past compare b");
        rd(BASE + 32'h04, BUS_W_WORD, 32'd1, "s1 status pend");

        // Auto-reload, COMPARE=3, tick every 3 clocks
        do_reset();
        wr(BASE + 32'h10, 32'd2, BUS_W_WORD);
        wr(BASE + 32'h0C, 32'd3, BUS_W_WORD);
        wr(BASE + 32'h00, 32'h7, BUS_W_WORD);
        e = cyc;
        for (int k = 0; k < 5; k++) begin
            rd(BASE + 32'h08, BUS_W_WORD, 32'(k % 4), $sformatf("s2 count step %0d", k));
        end
        rd(BASE + 32'h04, BUS_W_WORD, 32'd1, "s2 pend first period");
        wr(BASE + 32'h04, 32'd1, BUS_W_WORD);
        wait_cyc(e + 23);
        rd(BASE + 32'h04, BUS_W_WORD, 32'd0, "s2 pend cleared mid period");
        rd(BASE + 32'h04, BUS_W_WORD, 32'd1, "s2 pend second period");

        // W1C racing a new match: set wins, a later W1C clears
        do_reset();
        wr(BASE + 32'h10, 32'd0, BUS_W_WORD);
        wr(BASE + 32'h0C, 32'd2, BUS_W_WORD);
        wr(BASE + 32'h08, 32'd0, BUS_W_WORD);
        wr(BASE + 32'h00, 32'h7, BUS_W_WORD);
        e = cyc;
        wait_cyc(e + 5);
        wr(BASE + 32'h04, 32'd1, BUS_W_WORD);
        @(negedge clk);
        chk("s5 irq before race", {31'd0, irq_n}, 32'd0);
        wr(BASE + 32'h04, 32'd1, BUS_W_WORD);
        @(negedge clk);
        chk("s5 irq after race w1c", {31'd0, irq_n}, 32'd0);
        step();
        chk_irq("s5 irq after clean w1c", 1'b1);

        // Reset while answering a COUNT load
        do_reset();
        wr(BASE + 32'h0C, 32'd0, BUS_W_WORD);
        wr(BASE + 32'h00, 32'h3, BUS_W_WORD);
        wr(BASE + 32'h00, 32'h2, BUS_W_WORD);
        wr(BASE + 32'h08, 32'h1234, BUS_W_WORD);
        mode = BUS_MODE_READ; addr = BASE + 32'h08; reqw = BUS_W_WORD; stall = 1'b1;
        @(negedge clk);
        chk_rel("s6 stall");
        exp_q.push_back(32'h1234);
        step();
        stall = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        pop_chk("s6 present before reset");
        chk("s6 irq before reset", {31'd0, irq_n}, 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk_rel("s6 after reset");
        chk("s6 irq after reset", {31'd0, irq_n}, 32'd1);
        step();
        idle_in();
        rd(BASE + 32'h08, BUS_W_WORD, 32'h0, "s6 count");
        rd(BASE + 32'h0C, BUS_W_WORD, 32'hFFFF_FFFF, "s6 compare");
        rd(BASE + 32'h04, BUS_W_WORD, 32'h0, "s6 status");
        rd(BASE + 32'h00, BUS_W_WORD, 32'h0, "s6 ctrl");

        // 32-bit wrap without a flag
        do_reset();
        wr(BASE + 32'h0C, 32'h10, BUS_W_WORD);
        wr(BASE + 32'h08, 32'hFFFF_FFFF, BUS_W_WORD);
        wr(BASE + 32'h00, 32'h3, BUS_W_WORD);
        e = cyc;
        wait_cyc(e + 2);
        rd(BASE + 32'h08, BUS_W_WORD, 32'(cyc - e - 1), "s7 count after wrap");
        rd(BASE + 32'h04, BUS_W_WORD, 32'h0, "s7 no pend on wrap");
        chk_irq("s7 irq idle", 1'b1);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard drain: got %0d left expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
